// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows the EXE/MEM destinations and drives
// freeze/bubble/flush for IF/ID and ID/EX, plus saturating stall/flush counters.
module hazard_ctrl #(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             two_src,
  input  logic [4:0]       dest,
  input  logic             wb_en,
  input  logic             mem_r_en,
  input  logic             br_taken,
  input  logic             clr_cnt,
  output logic             freeze,
  output logic             bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       wb;
    logic       ld;
  } exe_slot_t;

  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       wb;
  } mem_slot_t;

  exe_slot_t        exe_q, exe_d;
  mem_slot_t        mem_q, mem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic match_exe, match_mem, hazard, issue;

  // Register 0 is hardwired, so a slot targeting it never blocks a reader.
  function automatic logic slot_match(input logic       v,
                                      input logic       wb,
                                      input logic [4:0] sd,
                                      input logic [4:0] s1,
                                      input logic [4:0] s2,
                                      input logic       two);
    return v & wb & (sd != 5'd0) & ((s1 == sd) | (two & (s2 == sd)));
  endfunction

  always_comb begin
    match_exe = slot_match(exe_q.v, exe_q.wb, exe_q.dest, src1, src2, two_src);
    match_mem = slot_match(mem_q.v, mem_q.wb, mem_q.dest, src1, src2, two_src);
    if (FWD_EN)
      hazard = match_exe & exe_q.ld;
    else
      hazard = match_exe | match_mem;
    freeze = id_valid & hazard;
    bubble = id_valid & hazard;
    flush  = id_valid & br_taken & ~freeze;
    issue  = id_valid & ~freeze;
  end

  always_comb begin
    exe_d = '0;
    if (issue) begin
      exe_d.v    = 1'b1;
      exe_d.dest = dest;
      exe_d.wb   = wb_en;
      exe_d.ld   = mem_r_en;
    end
    mem_d.v    = exe_q.v;
    mem_d.dest = exe_q.dest;
    mem_d.wb   = exe_q.wb;
  end

  // Clear takes priority over a same-cycle increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (freeze && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush  && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_q       <= '0;
      mem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      exe_q       <= exe_d;
      mem_q       <= mem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one DUT with forwarding (4-bit counters),
// one without (16-bit counters), sharing the same ID-stage stimulus.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, two_src, wb_en, mem_r_en, br_taken, clr_cnt;
  logic [4:0] src1, src2, dest;

  logic        f1_freeze, f1_bubble, f1_flush;
  logic [3:0]  f1_stall, f1_fcnt;
  logic        f0_freeze, f0_bubble, f0_flush;
  logic [15:0] f0_stall, f0_fcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(4)) dut_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .br_taken(br_taken), .clr_cnt(clr_cnt), .freeze(f1_freeze),
    .bubble(f1_bubble), .flush(f1_flush), .stall_cnt(f1_stall),
    .flush_cnt(f1_fcnt));

  hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(16)) dut_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .br_taken(br_taken), .clr_cnt(clr_cnt), .freeze(f0_freeze),
    .bubble(f0_bubble), .flush(f0_flush), .stall_cnt(f0_stall),
    .flush_cnt(f0_fcnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic two, input logic [4:0] d, input logic wb,
                        input logic ld, input logic br);
    id_valid = v; src1 = s1; src2 = s2; two_src = two;
    dest = d; wb_en = wb; mem_r_en = ld; br_taken = br;
    #1;
  endtask

  task automatic do_reset();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    clr_cnt = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; clr_cnt = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({f1_freeze, f1_bubble, f1_flush, f0_freeze, f0_bubble, f0_flush} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000",
               {f1_freeze, f1_bubble, f1_flush, f0_freeze, f0_bubble, f0_flush});
    end
    checks++;
    if (f1_stall !== 4'd0 || f1_fcnt !== 4'd0 || f0_stall !== 16'd0 || f0_fcnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters got %0d %0d %0d %0d exp 0 0 0 0",
               f1_stall, f1_fcnt, f0_stall, f0_fcnt);
    end
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (f1_flush !== 1'b1 || f1_freeze !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush_follows got flush=%b freeze=%b exp flush=1 freeze=0",
               f1_flush, f1_freeze);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw r5
    checks++;
    if (f1_freeze !== 1'b0) begin
      errors++; $display("FAIL lu_producer_freeze got %b exp 0", f1_freeze);
    end
    tick();
    set_id(1'b1, 5'd5, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // add r7,r5,r6
    checks++;
    if (f1_freeze !== 1'b1 || f1_bubble !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got freeze=%b bubble=%b exp 1 1", f1_freeze, f1_bubble);
    end
    tick();
    checks++;
    if (f1_freeze !== 1'b0 || f1_bubble !== 1'b0) begin
      errors++;
      $display("FAIL lu_release got freeze=%b bubble=%b exp 0 0", f1_freeze, f1_bubble);
    end
    checks++;
    if (f1_stall !== 4'd1) begin
      errors++; $display("FAIL lu_stall_cnt got %0d exp 1", f1_stall);
    end
  endtask

  task automatic test_raw_nofwd();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3
    tick();
    set_id(1'b1, 5'd4, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);   // sub r8,r4,r3
    checks++;
    if (f0_freeze !== 1'b1 || f1_freeze !== 1'b0) begin
      errors++;
      $display("FAIL raw_adj_c1 got nofwd=%b fwd=%b exp 1 0", f0_freeze, f1_freeze);
    end
    tick();
    checks++;
    if (f0_freeze !== 1'b1) begin
      errors++; $display("FAIL raw_adj_c2 got %b exp 1", f0_freeze);
    end
    tick();
    checks++;
    if (f0_freeze !== 1'b0 || f0_stall !== 16'd2) begin
      errors++;
      $display("FAIL raw_adj_done got freeze=%b cnt=%0d exp 0 2", f0_freeze, f0_stall);
    end

    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3
    tick();
    set_id(1'b1, 5'd10, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0); // independent
    checks++;
    if (f0_freeze !== 1'b0) begin
      errors++; $display("FAIL raw_gap_indep got %b exp 0", f0_freeze);
    end
    tick();
    set_id(1'b1, 5'd4, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);   // sub reads r3
    checks++;
    if (f0_freeze !== 1'b1) begin
      errors++; $display("FAIL raw_gap_c1 got %b exp 1", f0_freeze);
    end
    tick();
    checks++;
    if (f0_freeze !== 1'b0 || f0_stall !== 16'd1) begin
      errors++;
      $display("FAIL raw_gap_done got freeze=%b cnt=%0d exp 0 1", f0_freeze, f0_stall);
    end
  endtask

  task automatic test_zero_and_two_src();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);   // load to r0
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    checks++;
    if (f1_freeze !== 1'b0 || f0_freeze !== 1'b0) begin
      errors++;
      $display("FAIL zero_dest got fwd=%b nofwd=%b exp 0 0", f1_freeze, f0_freeze);
    end
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);   // lw r9
    tick();
    set_id(1'b1, 5'd1, 5'd9, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);   // src2 unused
    checks++;
    if (f1_freeze !== 1'b0 || f0_freeze !== 1'b0) begin
      errors++;
      $display("FAIL two_src_off got fwd=%b nofwd=%b exp 0 0", f1_freeze, f0_freeze);
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (f1_flush !== 1'b1 || f0_flush !== 1'b1) begin
      errors++;
      $display("FAIL br_flush got fwd=%b nofwd=%b exp 1 1", f1_flush, f0_flush);
    end
    tick();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw r5
    checks++;
    if (f1_fcnt !== 4'd1 || f0_fcnt !== 16'd1 || f1_flush !== 1'b0) begin
      errors++;
      $display("FAIL br_flush_cnt got %0d %0d flush=%b exp 1 1 0", f1_fcnt, f0_fcnt, f1_flush);
    end
    tick();
    set_id(1'b1, 5'd5, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);   // bne on r5, taken
    checks++;
    if (f1_freeze !== 1'b1 || f1_flush !== 1'b0) begin
      errors++;
      $display("FAIL br_hazard got freeze=%b flush=%b exp 1 0", f1_freeze, f1_flush);
    end
    tick();
    checks++;
    if (f1_freeze !== 1'b0 || f1_flush !== 1'b1) begin
      errors++;
      $display("FAIL br_after got freeze=%b flush=%b exp 0 1", f1_freeze, f1_flush);
    end
    tick();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (f1_fcnt !== 4'd2) begin
      errors++; $display("FAIL br_flush_cnt2 got %0d exp 2", f1_fcnt);
    end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    // lw r5,(r5) repeated: with forwarding this stalls every other cycle.
    set_id(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (f1_stall !== 4'd15) begin
      errors++; $display("FAIL sat_stall got %0d exp 15", f1_stall);
    end
    tick();
    checks++;
    if (f1_freeze !== 1'b1 || f1_stall !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold got freeze=%b cnt=%0d exp 1 15", f1_freeze, f1_stall);
    end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    #1;
    checks++;
    if (f1_stall !== 4'd0) begin
      errors++; $display("FAIL clr_wins got %0d exp 0", f1_stall);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw r5
    tick();
    set_id(1'b1, 5'd5, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // stalls 1 cycle
    tick();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw r5 again
    tick();
    set_id(1'b1, 5'd5, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    checks++;
    if (f1_freeze !== 1'b1 || f1_stall !== 4'd1) begin
      errors++;
      $display("FAIL mid_pre got freeze=%b cnt=%0d exp 1 1", f1_freeze, f1_stall);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (f1_freeze !== 1'b0 || f1_bubble !== 1'b0 || f1_stall !== 4'd0 || f0_stall !== 16'd0) begin
      errors++;
      $display("FAIL mid_async got freeze=%b bubble=%b cnt=%0d/%0d exp 0 0 0/0",
               f1_freeze, f1_bubble, f1_stall, f0_stall);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (f1_freeze !== 1'b0 || f0_freeze !== 1'b0) begin
      errors++;
      $display("FAIL mid_release got fwd=%b nofwd=%b exp 0 0", f1_freeze, f0_freeze);
    end
    tick();
    checks++;
    if (f1_stall !== 4'd0 || f1_freeze !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got cnt=%0d freeze=%b exp 0 0", f1_stall, f1_freeze);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_raw_nofwd();
    test_zero_and_two_src();
    test_branch();
    test_saturate_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. Sits beside the ID stage, consumes the ID-stage decoded register fields and control bits, and tracks its own shadow of the destination registers in flight in EXE and MEM. From these it drives the freeze, bubble and flush controls that sequence the IF/ID and ID/EX pipeline registers. It also keeps saturating stall and flush performance counters.

## Interface
- FWD_EN, 1: 1 = forwarding unit present, so only load-use stalls; 0 = no forwarding, so stall on any RAW hazard against EXE or MEM.
- CNT_W, 16: width of the performance counters.

- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted); clears all state immediately.
- id_valid  in  1  ID stage holds a valid instruction.
- src1  in  5  first source register read in ID.
- src2  in  5  second source register read in ID.
- two_src  in  1  src2 is actually read (R-type, store, BNE); 0 = ignore src2.
- dest  in  5  destination register of the ID instruction.
- wb_en  in  1  ID instruction writes dest.
- mem_r_en  in  1  ID instruction is a load.
- br_taken  in  1  branch resolved taken in ID.
- clr_cnt  in  1  synchronous clear of both counters.
- freeze  out  1  hold PC and IF/ID this cycle.
- bubble  out  1  load NOP (all enables 0) into ID/EX this cycle.
- flush  out  1  replace the IF/ID contents with NOP at the next edge.
- stall_cnt  out  CNT_W  cycles with freeze=1, saturating.
- flush_cnt  out  CNT_W  cycles with flush=1, saturating.

## Operation
- Shadow slots: EXE slot {v, dest, wb, ld}, MEM slot {v, dest, wb}. A slot with dest=0 never causes a hazard, whatever its wb value.
- issue = id_valid & ~freeze.
- Each edge:
  - If issue, EXE slot <= {1, dest, wb_en, mem_r_en}. Otherwise EXE slot <= invalid, because the bubble enters EX.
  - MEM slot <= EXE slot, fields wb and dest only.
- A match against slot S means S.v & S.wb & S.dest!=0 & (src1==S.dest | (two_src & src2==S.dest)).
- Hazard:
  - FWD_EN=1: match against EXE with EXE.ld=1.
  - FWD_EN=0: match against EXE, or match against MEM.
- freeze = bubble = id_valid & hazard.
- flush = id_valid & br_taken & ~freeze. A hazard overrides the branch, because branch operands are not yet valid. The branch itself still issues.
- Counters:
  - stall_cnt += 1 when freeze=1, and flush_cnt += 1 when flush=1.
  - Both saturate at 2^CNT_W-1.
  - When clr_cnt=1 the counters go to 0; clear wins over increment in the same cycle.

## Timing
- freeze, bubble and flush are combinational from the current inputs and the registered slots, valid in the same cycle. There is no registered delay.
- Slots and counters update on the rising clk edge. Effect on the hazard outputs appears in the next cycle.
- Stall length:
  - Load-use with FWD_EN=1: exactly 1 cycle.
  - FWD_EN=0: 2 cycles if the producer is directly ahead, 1 cycle if there is one instruction between producer and consumer.
- Reset (rst=0, async, also mid-operation):
  - Both slots go invalid and both counters go to 0 immediately.
  - freeze=bubble=0 unless id_valid is high with no slot state, which yields no hazard, so all three outputs read 0 while reset is asserted with the slots invalid.
  - flush still follows id_valid & br_taken.
- id_valid=0: all three outputs are 0 and EXE loads invalid.
- A register written in WB and read in ID in the same cycle is not a hazard; the register file writes before it reads.

## Test plan
- FWD_EN=1, issue lw dest=5, wb=1, ld=1. Next cycle, ID add src1=5 -> freeze=bubble=1 for exactly 1 cycle, then 0; stall_cnt=1.
- FWD_EN=0, add dest=3 followed by sub src2=3 with two_src=1 -> freeze for 2 consecutive cycles. Repeat with one independent instruction between them -> freeze for 1 cycle.
- Producer with dest=0 and wb=1, consumer reads src1=0 -> no freeze in either FWD_EN setting. Consumer src2 matches but two_src=0 -> no freeze.
- br_taken=1 with no hazard -> flush=1 and flush_cnt increments. br_taken=1 while a load-use hazard is pending -> flush=0 and freeze=1, then flush=1 in the following cycle.
- Drive freeze continuously with CNT_W=4 -> stall_cnt sticks at 15. Assert clr_cnt while freeze=1 -> stall_cnt=0 the next cycle.
- Assert rst=0 mid-stall with the EXE load slot valid -> slots and counters clear asynchronously and freeze drops without a clock edge. Release rst -> no stale hazard.
